// File: rtl/osum_deskew.sv
// Output-side de-skew for the systolic array: realigns per-column results into rows,
// buffers aligned rows in a small FIFO and presents them over valid/ready.
module osum_deskew #(
   parameter int WIDTH = 24,
   parameter int COLS  = 4,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic [COLS-1:0]         i_valid,
   input  logic [COLS*WIDTH-1:0]   i_data,
   output logic                    o_valid,
   input  logic                    o_ready,
   output logic [COLS*WIDTH-1:0]   o_data,
   output logic                    o_full,
   output logic                    o_overflow,
   output logic                    o_misalign
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [COLS-1:0]             al_v;
   logic [COLS-1:0][WIDTH-1:0]  al_d;

   // Column c waits COLS-1-c enabled edges so that every column lines up with the last one.
   genvar c;
   for (c = 0; c < COLS - 1; c++) begin : g_col
      localparam int N = COLS - 1 - c;
      logic [N-1:0][WIDTH:0] sh_q, sh_d;

      always_comb begin
         sh_d = sh_q;
         if (clr) begin
            sh_d = '0;
         end else if (en) begin
            sh_d[0] = {i_valid[c], i_data[c*WIDTH +: WIDTH]};
            for (int k = 1; k < N; k++) sh_d[k] = sh_q[k-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sh_q <= '0;
         else        sh_q <= sh_d;
      end

      assign al_v[c] = sh_q[N-1][WIDTH];
      assign al_d[c] = sh_q[N-1][WIDTH-1:0];
   end

   assign al_v[COLS-1] = i_valid[COLS-1];
   assign al_d[COLS-1] = i_data[(COLS-1)*WIDTH +: WIDTH];

   logic [COLS-1:0][WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d, mis_q, mis_d;
   logic          push_req, mixed, pop, wr_en, full;

   assign full     = (cnt_q == CW'(DEPTH));
   assign push_req = en & (&al_v);
   assign mixed    = en & (|al_v) & ~(&al_v);
   assign pop      = (cnt_q != '0) & o_ready & ~clr;
   // A full FIFO still accepts a row when the head leaves on the same edge.
   assign wr_en    = ~clr & push_req & (~full | pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      mis_d  = mis_q;
      if (clr) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
         mis_d  = 1'b0;
      end else begin
         if (wr_en) wptr_d = wptr_q + AW'(1);
         if (pop)   rptr_d = rptr_q + AW'(1);
         cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
         if (push_req & full & ~pop) ovf_d = 1'b1;
         if (mixed)                  mis_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         mis_q  <= mis_d;
      end
   end

   // Storage needs no reset: the output is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= al_d;
   end

   assign o_valid    = (cnt_q != '0);
   assign o_data     = o_valid ? mem_q[rptr_q] : '0;
   assign o_full     = full;
   assign o_overflow = ovf_q;
   assign o_misalign = mis_q;
endmodule

// File: tb/tb_osum_deskew.sv
// Randomized bench for osum_deskew: row-level reference model plus directed literal checks.
module tb_osum_deskew;
   localparam int WIDTH = 24;
   localparam int COLS  = 4;
   localparam int DEPTH = 4;
   localparam int RW    = COLS * WIDTH;
   localparam int HS    = 8192;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0, clr = 1'b0, o_ready = 1'b0;
   logic [COLS-1:0] i_valid = '0;
   logic [RW-1:0]   i_data = '0;
   logic            o_valid, o_full, o_overflow, o_misalign;
   logic [RW-1:0]   o_data;

   osum_deskew #(.WIDTH(WIDTH), .COLS(COLS), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .i_valid(i_valid), .i_data(i_data),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
      .o_full(o_full), .o_overflow(o_overflow), .o_misalign(o_misalign)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0;

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a === e) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, a, e);
   endtask

   // Reference model: history of what was presented on each enabled edge, plus a row queue.
   logic [COLS-1:0] hv [HS];
   logic [RW-1:0]   hd [HS];
   logic [RW-1:0]   mq [$];
   int              m_n = 0;
   bit              m_ovf = 0, m_mis = 0;

   function automatic void m_reset();
      mq.delete();
      m_ovf = 0;
      m_mis = 0;
      m_n   = 0;
   endfunction

   always @(posedge clk) begin
      logic [COLS-1:0] av;
      logic [RW-1:0]   ad;
      if (!rst_n) m_reset();
      else if (clr) m_reset();
      else begin
         if (mq.size() > 0 && o_ready) void'(mq.pop_front());
         if (en) begin
            hv[m_n % HS] = i_valid;
            hd[m_n % HS] = i_data;
            av = '0;
            ad = '0;
            for (int c = 0; c < COLS; c++) begin
               automatic int idx = m_n - (COLS - 1 - c);
               if (idx >= 0) begin
                  av[c] = hv[idx % HS][c];
                  ad[c*WIDTH +: WIDTH] = hd[idx % HS][c*WIDTH +: WIDTH];
               end
            end
            m_n++;
            if (&av) begin
               if (mq.size() < DEPTH) mq.push_back(ad);
               else m_ovf = 1;
            end else if (|av) m_mis = 1;
         end
      end
   end

   // Per-cycle comparison against the model, plus a log of rows the DUT hands off.
   logic [RW-1:0] dlog [$];
   always @(negedge clk) begin
      logic [RW-1:0] ed;
      ed = (mq.size() > 0) ? mq[0] : '0;
      chk("cycle", {o_valid, o_full, o_overflow, o_misalign, o_data},
          {mq.size() > 0, mq.size() == DEPTH, m_ovf, m_mis, ed});
      if (rst_n && !clr && o_valid && o_ready) dlog.push_back(o_data);
   end

   // Driver: rows are planned by the enabled-edge index at which column 0 is presented.
   logic [COLS-1:0] pmask [HS];
   logic [RW-1:0]   pdat  [HS];
   bit              pset  [HS];
   int              dn = 0;

   function automatic logic [RW-1:0] mkrow(input int base);
      logic [RW-1:0] r;
      for (int c = 0; c < COLS; c++) r[c*WIDTH +: WIDTH] = WIDTH'(base + c);
      return r;
   endfunction

   task automatic plan(input int off, input logic [COLS-1:0] m, input logic [RW-1:0] d);
      pset[dn+off]  = 1;
      pmask[dn+off] = m;
      pdat[dn+off]  = d;
   endtask

   task automatic cyc(input bit e, input bit r, input bit cl);
      logic [COLS-1:0] v;
      logic [RW-1:0]   d;
      for (int c = 0; c < COLS; c++) begin
         automatic int idx = dn - c;
         d[c*WIDTH +: WIDTH] = WIDTH'($urandom);
         v[c] = 1'b0;
         if (idx >= 0 && pset[idx]) begin
            v[c] = pmask[idx][c];
            if (v[c]) d[c*WIDTH +: WIDTH] = pdat[idx][c*WIDTH +: WIDTH];
         end
      end
      en = e; o_ready = r; clr = cl; i_valid = v; i_data = d;
      @(posedge clk);
      if (e) dn++;
      #1;
   endtask

   initial begin
      int first, rdy_pct;
      logic [RW-1:0] ra, rc, rx, rp, rq;
      @(posedge clk); #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_flags", {o_full, o_overflow, o_misalign}, 0);
      rst_n = 1'b1;

      // 1) three skewed rows, first o_valid after edge t+3, delivered in order
      dlog.delete();
      for (int r = 0; r < 3; r++) plan(r, '1, mkrow(10 * (r + 1)));
      first = -1;
      for (int k = 0; k < 10; k++) begin
         cyc(1, 1, 0);
         if (o_valid && first < 0) first = k;
      end
      chk("t1_latency", first, 3);
      chk("t1_n", dlog.size(), 3);
      for (int r = 0; r < 3 && r < dlog.size(); r++) chk("t1_row", dlog[r], mkrow(10 * (r + 1)));

      // 2) overflow with o_ready low, then drain rows 1-4
      cyc(1, 0, 1);
      dlog.delete();
      for (int r = 0; r < 5; r++) plan(r, '1, mkrow(100 * (r + 1)));
      for (int k = 0; k < 7; k++) cyc(1, 0, 0);
      chk("t2_full4", {o_full, o_overflow}, 2'b10);
      cyc(1, 0, 0);
      chk("t2_ovf", {o_full, o_overflow}, 2'b11);
      for (int k = 0; k < 8; k++) cyc(1, 1, 0);
      chk("t2_n", dlog.size(), 4);
      for (int r = 0; r < 4 && r < dlog.size(); r++) chk("t2_row", dlog[r], mkrow(100 * (r + 1)));
      chk("t2_empty", {o_full, o_valid}, 0);

      // 3) full FIFO, push and pop on the same edge
      cyc(1, 0, 1);
      dlog.delete();
      for (int r = 0; r < 5; r++) plan(r, '1, mkrow(1000 + 16 * r));
      for (int k = 0; k < 7; k++) cyc(1, 0, 0);
      cyc(1, 1, 0);
      chk("t3_still_full", {o_full, o_overflow}, 2'b10);
      for (int k = 0; k < 8; k++) cyc(1, 1, 0);
      chk("t3_n", dlog.size(), 5);
      if (dlog.size() == 5) chk("t3_last", dlog[4], mkrow(1000 + 64));

      // 4) misaligned row discarded, flag sticky until clr
      cyc(1, 0, 1);
      ra = mkrow(-5);
      rc = mkrow(777);
      plan(0, '1, ra);
      plan(1, 4'b1011, mkrow(333));
      plan(2, '1, rc);
      for (int k = 0; k < 7; k++) cyc(1, 0, 0);
      chk("t4_mis", o_misalign, 1);
      chk("t4_head", o_data, ra);
      cyc(1, 1, 0);
      chk("t4_next", o_data, rc);
      cyc(1, 0, 1);
      chk("t4_clr", {o_valid, o_misalign}, 0);

      // 5) stall mid-row while downstream drains two buffered rows
      dlog.delete();
      rp = mkrow(4000); rq = mkrow(5000); rx = mkrow(6000);
      plan(0, '1, rp); plan(1, '1, rq); plan(2, '1, rx);
      for (int k = 0; k < 5; k++) cyc(1, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0);
      chk("t5_drain_n", dlog.size(), 2);
      chk("t5_drained", o_valid, 0);
      for (int k = 0; k < 4; k++) cyc(1, 1, 0);
      chk("t5_n", dlog.size(), 3);
      if (dlog.size() == 3) chk("t5_x", dlog[2], rx);

      // 6) asynchronous reset with three rows buffered
      cyc(1, 0, 1);
      for (int r = 0; r < 3; r++) plan(r, '1, mkrow(7000 + r));
      for (int k = 0; k < 6; k++) cyc(1, 0, 0);
      chk("t6_buffered", o_valid, 1);
      #1; rst_n = 1'b0; m_reset();
      #1;
      chk("t6_async_valid", o_valid, 0);
      chk("t6_async_data", o_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dlog.delete();
      plan(0, '1, mkrow(8000));
      for (int k = 0; k < 8; k++) cyc(1, 1, 0);
      chk("t6_n", dlog.size(), 1);
      if (dlog.size() == 1) chk("t6_row", dlog[0], mkrow(8000));

      // randomized traffic, checked every cycle against the model
      rdy_pct = 95;
      for (int k = 0; k < 2500; k++) begin
         if (k % 200 == 0) rdy_pct = (k / 200) % 3 == 0 ? 95 : ((k / 200) % 3 == 1 ? 20 : 60);
         if (!pset[dn] && ($urandom % 2 == 0))
            plan(0, ($urandom % 10 == 0) ? COLS'($urandom) : '1,
                 {$urandom, $urandom, $urandom});
         cyc($urandom % 10 != 0, ($urandom % 100) < rdy_pct, $urandom % 150 == 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
